// File: rtl/ysyx_isram_resp_pkg.sv
// Shared types for the instruction-side SRAM responder: FSM state codes
// and the LFSR step used by the latency-jitter generator.
package ysyx_isram_resp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int unsigned LFSR_W = 8;

  // Fibonacci step for x^8+x^6+x^5+x^4+1, shifting toward the MSB.
  function automatic logic [LFSR_W-1:0] lfsr8_next(input logic [LFSR_W-1:0] q);
    return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction

endpackage

// File: rtl/ysyx_isram_resp_if.sv
// IFU fetch channel: word-read request (araddr/arvalid) and a single-cycle
// response (rdata/rvalid/rerr) with no back-pressure.
interface ysyx_isram_resp_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              rerr;

  modport master (output araddr, output arvalid, input rdata, input rvalid, input rerr);
  modport slave  (input araddr, input arvalid, output rdata, output rvalid, output rerr);
endinterface

// File: rtl/ysyx_lfsr8.sv
// 8-bit Fibonacci LFSR that steps only when enabled, so any consumer sees a
// sequence that is deterministic per seed and per number of enables.
module ysyx_lfsr8
  import ysyx_isram_resp_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [7:0] q
);

  logic [7:0] r_q;

  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst)     r_q <= SEED;
    else if (en) r_q <= lfsr8_next(r_q);
  end

  assign q = r_q;

endmodule

// File: rtl/ysyx_isram_resp.sv
// Slave end of the IFU fetch channel in front of a behavioural instruction
// SRAM: one request at a time, fixed plus optional jittered latency.
module ysyx_isram_resp
  import ysyx_isram_resp_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                MEM_AW    = 10,
  parameter logic [ADDR_W-1:0] BASE      = 32'h8000_0000,
  parameter int                LATENCY   = 2,
  parameter bit                RAND_LAT  = 1'b0,
  parameter int                RAND_W    = 3,
  parameter logic [7:0]        LFSR_SEED = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  ysyx_isram_resp_if.slave  ifu,
  output logic              busy_o,
  input  logic              ld_en,
  input  logic [MEM_AW-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data
);

  localparam int              CNT_W     = $clog2(LATENCY + (1 << RAND_W)) + 1;
  localparam logic [7:0]      JIT_MASK  = 8'((1 << RAND_W) - 1);
  localparam logic [ADDR_W:0] ADDR_LO   = {1'b0, BASE};
  // One bit wider than the bus so BASE + size cannot wrap at the top of memory.
  localparam logic [ADDR_W:0] ADDR_HI   = ADDR_LO + ((ADDR_W + 1)'(1) << (MEM_AW + 2));

  state_e              r_state;
  state_e              w_state_nxt;
  logic [ADDR_W-1:0]   r_addr;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_rerr;
  logic [DATA_W-1:0]   r_mem [2**MEM_AW];

  logic                w_accept;
  logic                w_read;
  logic [7:0]          w_lfsr_q;
  logic [CNT_W-1:0]    w_jitter;
  logic [CNT_W-1:0]    w_load;
  logic [ADDR_W-1:0]   w_rd_addr;
  logic [ADDR_W:0]     w_rd_ext;
  logic                w_err;
  logic [MEM_AW-1:0]   w_idx;

  ysyx_lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .en  (w_accept),
    .q   (w_lfsr_q)
  );

  assign w_jitter = RAND_LAT ? CNT_W'(w_lfsr_q & JIT_MASK) : '0;
  assign w_load   = CNT_W'(LATENCY - 1) + w_jitter;

  // A zero-length wait (LATENCY=1, no jitter) reads straight off the bus.
  assign w_rd_addr = (r_state == ST_IDLE) ? ifu.araddr : r_addr;
  assign w_rd_ext  = {1'b0, w_rd_addr};
  assign w_err     = (w_rd_addr[1:0] != 2'b00) || (w_rd_ext < ADDR_LO) || (w_rd_ext >= ADDR_HI);
  assign w_idx     = MEM_AW'(w_rd_addr[ADDR_W-1:2] - BASE[ADDR_W-1:2]);

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_read      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (ifu.arvalid) begin
          w_accept = 1'b1;
          if (w_load == '0) begin
            w_read      = 1'b1;
            w_state_nxt = ST_RESP;
          end else begin
            w_state_nxt = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        if (r_cnt == CNT_W'(1)) begin
          w_read      = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr  <= '0;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_rerr  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr <= ifu.araddr;
        r_cnt  <= w_load;
      end else if (r_state == ST_BUSY) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_read) begin
        r_rerr  <= w_err;
        r_rdata <= w_err ? '0 : r_mem[w_idx];
      end
    end
  end

  // NOTE: the SRAM array has no reset; preloaded contents survive rst, and a
  // same-edge preload to the word being read returns the old word.
  always_ff @(posedge clk) begin
    if (ld_en) r_mem[ld_addr] <= ld_data;
  end

  assign ifu.rvalid = (r_state == ST_RESP);
  assign ifu.rdata  = r_rdata;
  assign ifu.rerr   = r_rerr && (r_state == ST_RESP);
  assign busy_o     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_ysyx_isram_resp.sv
// Directed bench for ysyx_isram_resp: one fixed-latency instance and one
// jittered instance sharing clock and reset.
module tb_ysyx_isram_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic        busy_a, busy_b;
  logic        ld_en;
  logic [9:0]  ld_addr;
  logic [31:0] ld_data;
  logic        ld_en_b;
  logic [9:0]  ld_addr_b;
  logic [31:0] ld_data_b;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  ysyx_isram_resp_if #(.ADDR_W(32), .DATA_W(32)) ifu_a ();
  ysyx_isram_resp_if #(.ADDR_W(32), .DATA_W(32)) ifu_b ();

  ysyx_isram_resp dut_a (
    .clk     (clk),
    .rst     (rst),
    .ifu     (ifu_a),
    .busy_o  (busy_a),
    .ld_en   (ld_en),
    .ld_addr (ld_addr),
    .ld_data (ld_data)
  );

  ysyx_isram_resp #(.RAND_LAT(1'b1), .LFSR_SEED(8'hA5)) dut_b (
    .clk     (clk),
    .rst     (rst),
    .ifu     (ifu_b),
    .busy_o  (busy_b),
    .ld_en   (ld_en_b),
    .ld_addr (ld_addr_b),
    .ld_data (ld_data_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [9:0] idx, input logic [31:0] data);
    ld_en = 1'b1; ld_addr = idx; ld_data = data;
    tick();
    ld_en = 1'b0;
  endtask

  // Single request on the fixed-latency instance, measured from the cycle arvalid rises.
  task automatic req_a(input logic [31:0] addr, input int exp_lat,
                       input logic [31:0] exp_data, input logic exp_err, input string name);
    int lat;
    ifu_a.araddr = addr; ifu_a.arvalid = 1'b1;
    tick();
    lat = 1;
    ifu_a.arvalid = 1'b0;
    while (ifu_a.rvalid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    n_vec++;
    if (lat !== exp_lat) begin n_miss++; $display("FAIL %s_lat: got %0d want %0d", name, lat, exp_lat); end
    n_vec++;
    if (ifu_a.rdata !== exp_data) begin n_miss++; $display("FAIL %s_data: got %h want %h", name, ifu_a.rdata, exp_data); end
    n_vec++;
    if (ifu_a.rerr !== exp_err) begin n_miss++; $display("FAIL %s_err: got %b want %b", name, ifu_a.rerr, exp_err); end
    tick();
    n_vec++;
    if (ifu_a.rvalid !== 1'b0 || ifu_a.rerr !== 1'b0) begin
      n_miss++; $display("FAIL %s_pulse: got rvalid=%b rerr=%b want 0 0", name, ifu_a.rvalid, ifu_a.rerr);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ifu_a.arvalid = 1'b0; ifu_a.araddr = '0;
    ifu_b.arvalid = 1'b0; ifu_b.araddr = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    ld_en_b = 1'b0; ld_addr_b = '0; ld_data_b = '0;
    tick(); tick();
    n_vec++;
    if ({ifu_a.rvalid, ifu_a.rerr, busy_a} !== 3'b000) begin
      n_miss++; $display("FAIL reset_ctrl_a: got %b want 000", {ifu_a.rvalid, ifu_a.rerr, busy_a});
    end
    n_vec++;
    if (ifu_a.rdata !== 32'h0) begin n_miss++; $display("FAIL reset_rdata_a: got %h want 0", ifu_a.rdata); end
    n_vec++;
    if ({ifu_b.rvalid, ifu_b.rerr, busy_b} !== 3'b000 || ifu_b.rdata !== 32'h0) begin
      n_miss++; $display("FAIL reset_b: got %b/%h want 000/0", {ifu_b.rvalid, ifu_b.rerr, busy_b}, ifu_b.rdata);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_read();
    preload(10'd0, 32'h0000_0413);
    tick();
    ifu_a.araddr = 32'h8000_0000; ifu_a.arvalid = 1'b1;   // cycle T
    n_vec++;
    if (busy_a !== 1'b0 || ifu_a.rvalid !== 1'b0) begin
      n_miss++; $display("FAIL basic_T: got busy=%b rvalid=%b want 0 0", busy_a, ifu_a.rvalid);
    end
    tick();                                                 // T+1
    n_vec++;
    if (busy_a !== 1'b1 || ifu_a.rvalid !== 1'b0 || ifu_a.rerr !== 1'b0) begin
      n_miss++; $display("FAIL basic_T1: got busy=%b rvalid=%b rerr=%b want 1 0 0", busy_a, ifu_a.rvalid, ifu_a.rerr);
    end
    tick();                                                 // T+2
    ifu_a.arvalid = 1'b0;
    n_vec++;
    if (busy_a !== 1'b1 || ifu_a.rvalid !== 1'b1) begin
      n_miss++; $display("FAIL basic_T2: got busy=%b rvalid=%b want 1 1", busy_a, ifu_a.rvalid);
    end
    n_vec++;
    if (ifu_a.rdata !== 32'h0000_0413 || ifu_a.rerr !== 1'b0) begin
      n_miss++; $display("FAIL basic_data: got %h/%b want 00000413/0", ifu_a.rdata, ifu_a.rerr);
    end
    tick();                                                 // T+3
    n_vec++;
    if (busy_a !== 1'b0 || ifu_a.rvalid !== 1'b0 || ifu_a.rdata !== 32'h0000_0413) begin
      n_miss++; $display("FAIL basic_T3: got busy=%b rvalid=%b rdata=%h want 0 0 00000413", busy_a, ifu_a.rvalid, ifu_a.rdata);
    end
  endtask

  task automatic test_addr_check();
    req_a(32'h7FFF_FFFC, 2, 32'h0, 1'b1, "below_base");
    req_a(32'h8000_0002, 2, 32'h0, 1'b1, "misaligned");
    req_a(32'h8000_1000, 2, 32'h0, 1'b1, "past_top");
    preload(10'd1023, 32'hDEAD_BEEF);
    req_a(32'h8000_0FFC, 2, 32'hDEAD_BEEF, 1'b0, "last_word");
    req_a(32'hFFFF_FFFC, 2, 32'h0, 1'b1, "addr_max");
  endtask

  task automatic test_back_to_back();
    logic        exp_v;
    logic [31:0] exp_d;
    preload(10'd1, 32'h1111_1111);
    preload(10'd2, 32'h2222_2222);
    ifu_a.araddr = 32'h8000_0004; ifu_a.arvalid = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k == 1) ifu_a.araddr = 32'h8000_0008;
      exp_v = (k == 2 || k == 5 || k == 8);
      exp_d = (k == 2) ? 32'h1111_1111 : 32'h2222_2222;
      n_vec++;
      if (ifu_a.rvalid !== exp_v) begin
        n_miss++; $display("FAIL b2b_rvalid_T%0d: got %b want %b", k, ifu_a.rvalid, exp_v);
      end
      if (exp_v) begin
        n_vec++;
        if (ifu_a.rdata !== exp_d) begin
          n_miss++; $display("FAIL b2b_data_T%0d: got %h want %h", k, ifu_a.rdata, exp_d);
        end
      end
    end
    ifu_a.arvalid = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic test_reset_abort();
    ifu_a.araddr = 32'h8000_0000; ifu_a.arvalid = 1'b1;   // T
    tick();                                                 // T+1
    ifu_a.arvalid = 1'b0;
    rst = 1'b1;
    tick();                                                 // T+2
    n_vec++;
    if (ifu_a.rvalid !== 1'b0 || busy_a !== 1'b0) begin
      n_miss++; $display("FAIL abort_T2: got rvalid=%b busy=%b want 0 0", ifu_a.rvalid, busy_a);
    end
    rst = 1'b0;
    tick();                                                 // first cycle after rst drops
    n_vec++;
    if (ifu_a.rvalid !== 1'b0 || busy_a !== 1'b0) begin
      n_miss++; $display("FAIL abort_idle: got rvalid=%b busy=%b want 0 0", ifu_a.rvalid, busy_a);
    end
    req_a(32'h8000_0000, 2, 32'h0000_0413, 1'b0, "after_reset");
  endtask

  task automatic test_preload_hazard();
    preload(10'd5, 32'h5555_5555);
    preload(10'd6, 32'h6666_6666);
    // Write lands on the same edge as the read: old data expected.
    ifu_a.araddr = 32'h8000_0014; ifu_a.arvalid = 1'b1;
    tick();
    ifu_a.arvalid = 1'b0;
    ld_en = 1'b1; ld_addr = 10'd5; ld_data = 32'hAAAA_AAAA;
    tick();
    ld_en = 1'b0;
    n_vec++;
    if (ifu_a.rvalid !== 1'b1 || ifu_a.rdata !== 32'h5555_5555) begin
      n_miss++; $display("FAIL rbw_same: got rvalid=%b rdata=%h want 1 55555555", ifu_a.rvalid, ifu_a.rdata);
    end
    tick();
    // Write one edge earlier: new data expected.
    ifu_a.araddr = 32'h8000_0018; ifu_a.arvalid = 1'b1;
    ld_en = 1'b1; ld_addr = 10'd6; ld_data = 32'h7777_7777;
    tick();
    ifu_a.arvalid = 1'b0; ld_en = 1'b0;
    tick();
    n_vec++;
    if (ifu_a.rvalid !== 1'b1 || ifu_a.rdata !== 32'h7777_7777) begin
      n_miss++; $display("FAIL rbw_early: got rvalid=%b rdata=%h want 1 77777777", ifu_a.rvalid, ifu_a.rdata);
    end
    tick();
    req_a(32'h8000_0014, 2, 32'hAAAA_AAAA, 1'b0, "rbw_landed");
  endtask

  task automatic test_jitter();
    logic [7:0] m;
    int         lat;
    int         exp_lat;
    int         seq [2][16];
    for (int pass = 0; pass < 2; pass++) begin
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      m = 8'hA5;
      for (int i = 0; i < 16; i++) begin
        exp_lat = 2 + int'(m[2:0]);
        ifu_b.araddr = 32'h8000_0000 + 32'(i * 4); ifu_b.arvalid = 1'b1;
        tick();
        lat = 1;
        ifu_b.arvalid = 1'b0;
        while (ifu_b.rvalid !== 1'b1 && lat < 30) begin
          tick();
          lat++;
        end
        seq[pass][i] = lat;
        n_vec++;
        if (lat !== exp_lat || ifu_b.rerr !== 1'b0) begin
          n_miss++; $display("FAIL jitter_p%0d_r%0d: got lat=%0d rerr=%b want lat=%0d rerr=0", pass, i, lat, ifu_b.rerr, exp_lat);
        end
        n_vec++;
        if (lat < 2 || lat > 9) begin
          n_miss++; $display("FAIL jitter_range_p%0d_r%0d: got %0d want 2..9", pass, i, lat);
        end
        m = {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]};
        tick();
      end
    end
    for (int i = 0; i < 16; i++) begin
      n_vec++;
      if (seq[1][i] !== seq[0][i]) begin
        n_miss++; $display("FAIL jitter_repeat_r%0d: got %0d want %0d", i, seq[1][i], seq[0][i]);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic_read();
    test_addr_check();
    test_back_to_back();
    test_reset_abort();
    test_preload_hazard();
    test_jitter();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/ysyx_isram_resp.md
Name: ysyx_isram_resp

Overview:
Instruction-side memory responder: the slave end of the IFU fetch interface (araddr/arvalid request, rdata/rvalid response). It accepts one word-read request at a time, waits a configurable and optionally jittered latency, then returns a single-cycle rvalid pulse with data or an error flag. It sits between the IFU and a behavioural instruction SRAM. Benches and the boot path fill the SRAM through a preload write port.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MEM_AW, 10, log2 of SRAM depth in words (default 4 KiB)
BASE, 32'h8000_0000, byte address of word 0
LATENCY, 2, minimum cycles from accept to rvalid; must be >= 1
RAND_LAT, 0, 1 = add LFSR jitter of 0..2^RAND_W-1 cycles
RAND_W, 3, jitter width in bits
LFSR_SEED, 8'hA5, nonzero LFSR reset value

Ports:
clk  in  1  clock; the only clock
rst  in  1  synchronous, active-high reset
ifu_araddr  in  ADDR_W  request byte address
ifu_arvalid  in  1  request valid
ifu_rdata  out  DATA_W  response data, valid only with ifu_rvalid
ifu_rvalid  out  1  single-cycle response pulse
ifu_rerr  out  1  response error, qualified by ifu_rvalid
busy_o  out  1  high in BUSY or RESP
ld_en  in  1  preload write enable
ld_addr  in  MEM_AW  preload word index
ld_data  in  DATA_W  preload data

Behaviour:
- Reset: state IDLE; ifu_rvalid=0, ifu_rdata=0, ifu_rerr=0, busy_o=0; counter=0; LFSR=LFSR_SEED. SRAM contents are not cleared.
- Reset mid-operation aborts the transaction. No rvalid is produced for it. The block is in IDLE the cycle after rst drops.
- FSM has three states: IDLE, BUSY, RESP.
- IDLE with arvalid=1 accepts the request (cycle T):
  - latch araddr;
  - load counter with LATENCY-1+jitter, where jitter = LFSR[RAND_W-1:0] if RAND_LAT else 0;
  - go to BUSY.
- IDLE with arvalid=0: remain in IDLE.
- BUSY: decrement counter each cycle. When counter==0, read the SRAM with the latched address, register rdata/rerr, and go to RESP.
- RESP: ifu_rvalid=1 for exactly this cycle. Response arrives at cycle T+LATENCY+jitter. Next state is IDLE unconditionally.
- ifu_arvalid and ifu_araddr are ignored outside IDLE. The latched address is used even if the bus address changes during BUSY.
- An initiator still holding arvalid in the IDLE cycle after RESP issues a new request. Back-to-back requests are therefore spaced LATENCY+1 cycles apart (one dead cycle).
- No rready: the initiator must capture data on rvalid.
- Address check, computed on the latched address:
  - error if araddr[1:0]!=0, or araddr<BASE, or araddr>=BASE+4*2^MEM_AW;
  - on error: rdata=0, rerr=1, and the SRAM is not read;
  - otherwise word index = (araddr-BASE)[MEM_AW+1:2].
  - Compute the upper bound without overflow, using an ADDR_W+1 wide compare.
- Preload: ld_en writes ld_data to ld_addr on that clock edge, in any state.
  - If a preload write hits the index being read in the same cycle the SRAM is read, the old data is returned (read-before-write).
  - A preload during BUSY that lands before the read cycle is reflected in the response.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. It advances only on an accepted request, so the jitter sequence is deterministic per seed. The LFSR is present but unused when RAND_LAT=0.
- Outside RESP, ifu_rdata holds its last value and ifu_rerr holds 0.

Decomposition:
- FSM state codes go in the shared macro file alongside the existing bus FSM codes: IDLE, plus new BUSY and RESP.
- One sub-module, ysyx_lfsr8 (clk, rst, en, seed param, q[7:0]), reusable for other latency-jitter models.
- The SRAM array stays inline.

Test Plan:
- Preload word0=32'h0000_0413; arvalid=1 @0x8000_0000 at cycle 10, dropped at 12 -> rvalid only at cycle 12, rdata=32'h0000_0413, rerr=0, busy_o high cycles 11-12.
- Request 0x7FFF_FFFC, then 0x8000_0002, then 0x8000_1000 -> each gives rvalid at T+2 with rdata=0, rerr=1. Request 0x8000_0FFC with word 1023 preloaded to 32'hDEAD_BEEF -> rerr=0, rdata=32'hDEAD_BEEF.
- arvalid held high continuously from T on 0x8000_0004 -> rvalid pulses at T+2, T+5, T+8. araddr changed to 0x8000_0008 at T+1 -> first response still carries word1.
- Reset asserted at T+1 of a pending request -> no rvalid ever produced for it. New request at the cycle after reset drops -> response LATENCY cycles later.
- ld_en to the in-flight word at the read cycle -> old data returned. Same write one cycle earlier -> new data returned.
- RAND_LAT=1, seed 8'hA5, 16 sequential requests -> every latency in [2,9]. Latency sequence matches the reference LFSR model and repeats identically after reset.
